y86_serial_addsub: RTL and testbench

//   Multi-cycle digit-serial 64-bit adder/subtractor for the Y86 execute stage (addq/subq path).

---
 rtl/y86_serial_addsub.sv | 113 +++++++++++
 tb/tb_y86_serial_addsub.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/y86_serial_addsub.sv
// Digit-serial add/subtract unit for the Y86 execute stage: processes DIGIT bits per clock,
// LSB digit first, and reports the sum plus ZF/SF/OF over valid/ready handshakes.
module y86_serial_addsub #(
    parameter int WIDTH = 64,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] result,
    output logic             zf,
    output logic             sf,
    output logic             of
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] result_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic             zf_r;
    logic             sf_r;
    logic             of_r;

    logic [IW-1:0]    idx_s;
    logic [DIGIT:0]   dsum_s;
    logic [WIDTH-1:0] res_nx_s;
    logic             of_nx_s;

    // One digit of the ripple sum; b_r already holds ~b for subtraction so the
    // overflow rule collapses to "operands agree in sign, result disagrees".
    always_comb begin
        idx_s    = IW'(int'(cnt_r) * DIGIT);
        dsum_s   = {1'b0, a_r[idx_s +: DIGIT]} + {1'b0, b_r[idx_s +: DIGIT]}
                 + {{DIGIT{1'b0}}, carry_r};
        res_nx_s = result_r;
        res_nx_s[idx_s +: DIGIT] = dsum_s[DIGIT-1:0];
        of_nx_s  = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (res_nx_s[WIDTH-1] != a_r[WIDTH-1]);
    end

    // Control FSM, operand latches, digit accumulation and flag capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            result_r <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            zf_r     <= 1'b0;
            sf_r     <= 1'b0;
            of_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        a_r     <= a;
                        b_r     <= op ? ~b : b;
                        carry_r <= op;
                        cnt_r   <= {CW{1'b0}};
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_r <= IDLE;
                    end else begin
                        result_r <= res_nx_s;
                        carry_r  <= dsum_s[DIGIT];
                        if (cnt_r == LAST) begin
                            cnt_r   <= {CW{1'b0}};
                            zf_r    <= (res_nx_s == {WIDTH{1'b0}});
                            sf_r    <= res_nx_s[WIDTH-1];
                            of_r    <= of_nx_s;
                            state_r <= DONE;
                        end else begin
                            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                DONE: begin
                    if (abort || rsp_ready) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_r == IDLE);
    assign rsp_valid = (state_r == DONE);
    assign result    = result_r;
    assign zf        = zf_r;
    assign sf        = sf_r;
    assign of        = of_r;
endmodule

// File: tb/tb_y86_serial_addsub.sv
// Bench for y86_serial_addsub: three instances (DIGIT=8, 1, 64) share the request side and
// are checked against a plain-arithmetic model of add/sub and Y86 flags.
module tb_y86_serial_addsub;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, req_valid, op, abort, rsp_ready;
    logic [63:0] a, b;
    logic [2:0]  rr, rv, zf, sf, of;
    logic [63:0] res [3];

    int checks = 0;
    int errors = 0;
    int dig [3]     = '{8, 1, 64};
    int lat_exp [3] = '{8, 64, 1};

    y86_serial_addsub #(.WIDTH(64), .DIGIT(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr[0]), .op(op), .a(a), .b(b),
        .abort(abort), .rsp_valid(rv[0]), .rsp_ready(rsp_ready), .result(res[0]),
        .zf(zf[0]), .sf(sf[0]), .of(of[0]));
    y86_serial_addsub #(.WIDTH(64), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr[1]), .op(op), .a(a), .b(b),
        .abort(abort), .rsp_valid(rv[1]), .rsp_ready(rsp_ready), .result(res[1]),
        .zf(zf[1]), .sf(sf[1]), .of(of[1]));
    y86_serial_addsub #(.WIDTH(64), .DIGIT(64)) u_d64 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr[2]), .op(op), .a(a), .b(b),
        .abort(abort), .rsp_valid(rv[2]), .rsp_ready(rsp_ready), .result(res[2]),
        .zf(zf[2]), .sf(sf[2]), .of(of[2]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Overflow taken from a 65-bit signed result that cannot itself overflow.
    task automatic ref_model(input logic o, input logic [63:0] x, input logic [63:0] y,
                             output logic [63:0] r, output logic [2:0] f);
        logic [64:0] full;
        full = o ? ({x[63], x} - {y[63], y}) : ({x[63], x} + {y[63], y});
        r = full[63:0];
        f = {(r == 64'd0), r[63], (full[64] != full[63])};
    endtask

    task automatic wait_idle();
        rsp_ready = 1'b1;
        for (int i = 0; i < 100 && rr != 3'b111; i++) begin
            @(posedge clk); #1;
        end
        check("idle", {61'd0, rr}, 64'd7);
    endtask

    task automatic issue(input logic o, input logic [63:0] x, input logic [63:0] y);
        op = o; a = x; b = y; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = 1'($urandom);
    endtask

    task automatic do_op(input logic o, input logic [63:0] x, input logic [63:0] y, input string tag);
        logic [63:0] er;
        logic [2:0]  ef;
        int          lat [3];
        logic [63:0] gr [3];
        logic [2:0]  gf [3];
        ref_model(o, x, y, er, ef);
        wait_idle();
        for (int k = 0; k < 3; k++) begin lat[k] = -1; gr[k] = 64'd0; gf[k] = 3'd0; end
        issue(o, x, y);
        for (int cyc = 1; cyc <= 70; cyc++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                if (rv[k] && lat[k] < 0) begin
                    lat[k] = cyc; gr[k] = res[k]; gf[k] = {zf[k], sf[k], of[k]};
                end
            end
            if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
        end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_lat_d%0d", tag, dig[k]), 64'(lat[k]), 64'(lat_exp[k]));
            check($sformatf("%s_res_d%0d", tag, dig[k]), gr[k], er);
            check($sformatf("%s_flags_d%0d", tag, dig[k]), {61'd0, gf[k]}, {61'd0, ef});
        end
    endtask

    initial begin
        logic        hold_ok;
        logic        quiet;
        logic [63:0] x, y;
        rst_n = 1'b0; req_valid = 1'b0; op = 1'b0; a = 64'd0; b = 64'd0;
        abort = 1'b0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", {61'd0, rr}, 64'd7);
        check("rst_rsp_valid", {61'd0, rv}, 64'd0);
        check("rst_result", res[0], 64'd0);
        check("rst_flags", {55'd0, zf, sf, of}, 64'd0);
        rst_n = 1'b1;

        do_op(1'b0, 64'd5, 64'd7, "t1_add");
        do_op(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, "t2_ovf");
        do_op(1'b1, 64'h8000_0000_0000_0000, 64'd1, "t3_subovf");
        do_op(1'b1, 64'd3, 64'd3, "t3_zero");

        // abort on the third RUN edge; flags must keep the zero result's values
        wait_idle();
        issue(1'b0, 64'd1, 64'd2);
        repeat (2) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_rsp_valid", {63'd0, rv[0]}, 64'd0);
        check("abort_idle", {62'd0, rr[1:0]}, 64'd3);
        check("abort_flags", {61'd0, zf[0], sf[0], of[0]}, 64'd4);
        quiet = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (rv[0] || rv[1]) quiet = 1'b0;
        end
        check("abort_no_rsp", {63'd0, quiet}, 64'd1);
        do_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "t5_neg");

        // backpressure on the DIGIT=8 instance
        wait_idle();
        rsp_ready = 1'b0;
        issue(1'b0, 64'd5, 64'd7);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 7) check("bp_early", {63'd0, rv[0]}, 64'd0);
        end
        check("bp_valid", {63'd0, rv[0]}, 64'd1);
        check("bp_result", res[0], 64'd12);
        hold_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (!rv[0] || rr[0] || res[0] != 64'd12 || {zf[0], sf[0], of[0]} != 3'b000) hold_ok = 1'b0;
        end
        check("bp_hold", {63'd0, hold_ok}, 64'd1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", {63'd0, rv[0]}, 64'd0);
        check("bp_release_ready", {63'd0, rr[0]}, 64'd1);

        // asynchronous reset in the middle of RUN
        wait_idle();
        issue(1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        check("mrst_req_ready", {61'd0, rr}, 64'd7);
        check("mrst_rsp_valid", {61'd0, rv}, 64'd0);
        check("mrst_result_d8", res[0], 64'd0);
        check("mrst_result_d1", res[1], 64'd0);
        check("mrst_flags", {55'd0, zf, sf, of}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 300; n++) begin
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: y = x;
                1: x = 64'h8000_0000_0000_0000;
                2: x = 64'h7FFF_FFFF_FFFF_FFFF;
                3: y = 64'hFFFF_FFFF_FFFF_FFFF;
                default: ;
            endcase
            do_op(1'($urandom), x, y, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
